// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between the client FSMs and the shared interval counter.
// The master side raises requests with terminal counts; the slave side arbitrates and counts.
interface counter_scheduler_if #(
  parameter int Size       = 5,
  parameter int Requesters = 4
);
  logic [Requesters-1:0]      req;
  logic [Requesters*Size-1:0] interval;
  logic [Requesters-1:0]      grant;
  logic [Requesters-1:0]      done;
  logic                       busy;
  logic [Size-1:0]            count;

  modport master (
    output req, interval,
    input  grant, done, busy, count
  );

  modport slave (
    input  req, interval,
    output grant, done, busy, count
  );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin sharing of one up-counter as an interval timer among several clients.
// The owner's counter runs 0..term, then the owner gets a one-cycle done pulse.
module counter_scheduler #(
  parameter int Size       = 5,
  parameter int Requesters = 4
) (
  input logic                clock,
  input logic                reset,
  counter_scheduler_if.slave bus
);

  localparam int PtrW = (Requesters > 1) ? $clog2(Requesters) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       owner_q, owner_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [Size-1:0]       term_q, term_d;
  logic [Size-1:0]       count_q, count_d;
  logic [Requesters-1:0] grant_q, grant_d;
  logic [Requesters-1:0] done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  win_found;
  logic [PtrW-1:0]       win_idx;

  function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] i);
    return (int'(i) == Requesters - 1) ? '0 : i + 1'b1;
  endfunction

  // First active requester at or after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < Requesters; i++) begin
      if (!win_found && bus.req[(int'(ptr_q) + i) % Requesters]) begin
        win_found = 1'b1;
        win_idx   = PtrW'((int'(ptr_q) + i) % Requesters);
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    term_d  = term_q;
    count_d = count_q;
    grant_d = '0;
    done_d  = '0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (win_found) begin
          state_d          = RUN;
          owner_d          = win_idx;
          term_d           = bus.interval[int'(win_idx)*Size +: Size];
          grant_d[win_idx] = 1'b1;
        end
      end
      RUN: begin
        // A dropped request wins over reaching the terminal count.
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          count_d = '0;
          ptr_d   = next_idx(owner_q);
        end else if (count_q == term_q) begin
          state_d         = DONE;
          done_d[owner_q] = 1'b1;
        end else begin
          grant_d[owner_q] = 1'b1;
          count_d          = count_q + Size'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
        ptr_d   = next_idx(owner_q);
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      term_q  <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      term_q  <= term_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule
